// File: rtl/mouse_bus_bridge_if.sv
// mouse_bus_bridge_if: processor-side control signals of the mouse bus bridge.
//   BUS_ADDR            processor address (master -> slave)
//   BUS_WE              1 = write, 0 = read (master -> slave)
//   BUS_INTERRUPT_ACK   interrupt acknowledge (master -> slave)
//   BUS_INTERRUPT_RAISE interrupt request (slave -> master)
// The tristate data bus stays a plain inout port on the bridge.
interface mouse_bus_bridge_if;
    logic [7:0] BUS_ADDR;
    logic       BUS_WE;
    logic       BUS_INTERRUPT_ACK;
    logic       BUS_INTERRUPT_RAISE;
    modport master (output BUS_ADDR, BUS_WE, BUS_INTERRUPT_ACK, input BUS_INTERRUPT_RAISE);
    modport slave  (input BUS_ADDR, BUS_WE, BUS_INTERRUPT_ACK, output BUS_INTERRUPT_RAISE);
endinterface

// File: rtl/mouse_bus_bridge.sv
// mouse_bus_bridge: buffers mouse packets in a FIFO and exposes them through a 5-register bus window.
//   CLK, RESET        clock, synchronous active-high reset
//   MOUSE_EVENT       one-cycle strobe, MOUSE_STATUS/MOUSE_X/MOUSE_Y are valid with it
//   BUS_DATA          tristate data bus, driven only in the cycle after a read hit
//   bus (slave)       BUS_ADDR, BUS_WE, BUS_INTERRUPT_ACK in, BUS_INTERRUPT_RAISE out
// Registers at BASE_ADDR+: 0 status, 1 X, 2 Y, 3 info {ovf,full,empty,count} (write pops),
// 4 control {clr_ovf,flush,ie}.
// Define MOUSE_FIFO_OVERWRITE_EN to make a push into a full FIFO replace the oldest entry
// instead of dropping the new one.
module mouse_bus_bridge #(
    parameter logic [7:0] BASE_ADDR  = 8'hA0,
    parameter int         FIFO_DEPTH = 8
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       MOUSE_EVENT,
    input  logic [3:0] MOUSE_STATUS,
    input  logic [7:0] MOUSE_X,
    input  logic [7:0] MOUSE_Y,
    inout  wire  [7:0] BUS_DATA,
    mouse_bus_bridge_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [4:0] DEPTH = 5'(FIFO_DEPTH);
    logic [19:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wp, rp;
    logic [4:0] count;
    logic ovf, ie, raise, rd_valid;
    logic [7:0] rd_data, rd_next, off;
    logic [19:0] head;
    logic hit, wr, ctl_wr, pop, flush, clr_ovf, empty, full, push_ok, push_full, store, drop_head;
    always_comb begin
        // Offsets below BASE_ADDR wrap to large values, so one compare bounds the window.
        off = bus.BUS_ADDR - BASE_ADDR;
        hit = off <= 8'd4;
        wr = hit && bus.BUS_WE;
        ctl_wr = wr && off == 8'd4;
        empty = count == 5'd0;
        full = count == DEPTH;
        pop = wr && off == 8'd3 && !empty;
        flush = ctl_wr && BUS_DATA[1];
        clr_ovf = ctl_wr && BUS_DATA[2];
        // A same-cycle pop frees a slot, so a push into a full FIFO is still accepted.
        push_ok = MOUSE_EVENT && (!full || pop);
        push_full = MOUSE_EVENT && full && !pop;
`ifdef MOUSE_FIFO_OVERWRITE_EN
        store = push_ok || push_full;
        drop_head = pop || push_full;
`else
        store = push_ok;
        drop_head = pop;
`endif
        head = mem[rp];
        rd_next = off == 8'd0 ? (empty ? 8'h00 : {4'h0, head[19:16]}) :
                  off == 8'd1 ? (empty ? 8'h00 : head[15:8]) :
                  off == 8'd2 ? (empty ? 8'h00 : head[7:0]) :
                  off == 8'd3 ? {ovf, full, empty, count} :
                  {7'b0, ie};
    end
    always_ff @(posedge CLK)
        if (store)
            mem[wp] <= {MOUSE_STATUS, MOUSE_X, MOUSE_Y};
    always_ff @(posedge CLK) begin
        if (RESET) begin
            wp <= '0;
            rp <= '0;
            count <= 5'd0;
            ovf <= 1'b0;
            ie <= 1'b1;
            raise <= 1'b0;
            rd_valid <= 1'b0;
            rd_data <= 8'h00;
        end else begin
            rd_valid <= hit && !bus.BUS_WE;
            rd_data <= rd_next;
            // A new event outranks a same-cycle acknowledge.
            raise <= (store && !flush && ie) || (raise && !bus.BUS_INTERRUPT_ACK);
            if (ctl_wr)
                ie <= BUS_DATA[0];
            if (flush) begin
                wp <= '0;
                rp <= '0;
                count <= 5'd0;
                ovf <= ovf && !clr_ovf;
            end else begin
                if (store)
                    wp <= wp + 1'b1;
                if (drop_head)
                    rp <= rp + 1'b1;
                count <= count + 5'(push_ok) - 5'(pop);
                ovf <= (ovf && !clr_ovf) || push_full;
            end
        end
    end
    assign BUS_DATA = rd_valid ? rd_data : 8'hzz;
    assign bus.BUS_INTERRUPT_RAISE = raise;
endmodule

// File: doc/mouse_bus_bridge.md
MOUSE_BUS_BRIDGE -- requirements
Module: mouse_bus_bridge

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 8'hA0: bus base address; the register window is BASE_ADDR..BASE_ADDR+4.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8: event FIFO depth; legal values are 2, 4, 8 and 16.
REQ-003 SHALL have port CLK, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port RESET, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port MOUSE_EVENT, input, 1 bit: one-cycle strobe from the mouse transceiver meaning a new packet is valid.
REQ-006 SHALL have port MOUSE_STATUS, input, 4 bits: button/sign status, sampled on MOUSE_EVENT.
REQ-007 SHALL have ports MOUSE_X and MOUSE_Y, input, 8 bits each: position, sampled on MOUSE_EVENT.
REQ-008 SHALL have port BUS_DATA, inout, 8 bits: processor data bus; driven only during a read response, otherwise high-Z.
REQ-009 SHALL have port BUS_ADDR, input, 8 bits: processor address.
REQ-010 SHALL have port BUS_WE, input, 1 bit: 1 = processor write, 0 = processor read.
REQ-011 SHALL have port BUS_INTERRUPT_RAISE, output, 1 bit: interrupt request to the processor.
REQ-012 SHALL have port BUS_INTERRUPT_ACK, input, 1 bit: interrupt acknowledge from the processor.

Function
REQ-013 Each FIFO entry SHALL be {status[3:0], x[7:0], y[7:0]}, 20 bits.
REQ-014 Register map SHALL be: +0 head status {4'h0,status}; +1 head X; +2 head Y; +3 FIFO info {ovf,full,empty,count[4:0]}; +4 control {5'b0,clr_ovf,flush,ie}.
REQ-015 A read SHALL be registered: address match with BUS_WE=0 in cycle N drives BUS_DATA in cycle N+1 only; otherwise BUS_DATA SHALL be high-Z.
REQ-016 Reads of +0..+2 while the FIFO is empty SHALL return 8'h00.
REQ-017 A write to +3, any data, SHALL pop the head entry; a pop while empty SHALL be ignored.
REQ-018 A write to +4 SHALL store ie; flush=1 SHALL empty the FIFO; clr_ovf=1 SHALL clear ovf; flush and clr_ovf self-clear and read back 0.
REQ-019 MOUSE_EVENT while not full SHALL push one entry; count SHALL update on the next edge.
REQ-020 A simultaneous push and pop SHALL leave count unchanged, and the push SHALL be accepted even when the FIFO is full.
REQ-021 A push while full with no pop SHALL set the sticky ovf flag; entry handling is per REQ-026/027.
REQ-022 Flush SHALL take priority over a same-cycle push and pop; count becomes 0 and the push is lost.
REQ-023 Read and write pointers SHALL wrap modulo FIFO_DEPTH; count SHALL range 0..FIFO_DEPTH.
REQ-024 BUS_INTERRUPT_RAISE SHALL set on the edge after an accepted push when ie=1, clear on the edge after BUS_INTERRUPT_ACK, and a push in the same cycle as ACK SHALL win (RAISE stays 1).

Reset
REQ-025 RESET SHALL give: FIFO empty, count 0, pointers 0, ovf 0, ie 1, BUS_INTERRUPT_RAISE 0, BUS_DATA high-Z; RESET mid-read SHALL cancel the pending response.

Configuration
REQ-026 With MOUSE_FIFO_OVERWRITE_EN defined, a push while full SHALL discard the oldest entry, store the new one, leave count at FIFO_DEPTH, and set ovf.
REQ-027 Without MOUSE_FIFO_OVERWRITE_EN, a push while full SHALL drop the new event, leave the FIFO unchanged, and set ovf.

Verification
REQ-028 Reset, then MOUSE_EVENT with status 4'h9, X 8'h12, Y 8'h34 -> read +0/+1/+2 gives 8'h09/8'h12/8'h34, and +3 gives 8'h01.
REQ-029 Push 9 events (values 1..9) with FIFO_DEPTH=8 -> +3 reads 8'hC8; head X is 1 (no macro) or 2 (macro defined).
REQ-030 Full FIFO with a push and a pop on the same cycle -> count stays 8, ovf stays 0, and the new entry lands at the tail.
REQ-031 MOUSE_EVENT and BUS_INTERRUPT_ACK on the same cycle -> RAISE stays 1; ACK alone next cycle -> RAISE is 0 on the following edge.
REQ-032 Write 8'h02 to +4 while a push occurs -> +3 reads 8'h20 and the pushed event is absent.
REQ-033 Write 8'h00 to +4, then push -> RAISE stays 0; read of BUS_ADDR 8'hA5 -> BUS_DATA stays high-Z.
